// File: rtl/front_panel_sw_if.sv
// Raw front-panel switch pins and conditioned panel outputs for front_panel_sw.
interface front_panel_sw_if;
    logic examn;
    logic contn;
    logic extd_addrn;
    logic addr_loadn;
    logic clearn;
    logic depn;
    logic haltn;
    logic single_stepn;
    logic exam_p;
    logic cont_p;
    logic extd_addr_p;
    logic addr_load_p;
    logic clear_p;
    logic dep_p;
    logic halt;
    logic single_step;
    logic sw_busy;

    modport master (
        output examn, contn, extd_addrn, addr_loadn, clearn, depn, haltn, single_stepn,
        input  exam_p, cont_p, extd_addr_p, addr_load_p, clear_p, dep_p, halt, single_step, sw_busy
    );

    modport slave (
        input  examn, contn, extd_addrn, addr_loadn, clearn, depn, haltn, single_stepn,
        output exam_p, cont_p, extd_addr_p, addr_load_p, clear_p, dep_p, halt, single_step, sw_busy
    );
endinterface

// File: rtl/front_panel_sw.sv
// Front-panel switch conditioner: 2-flop sync, debounce, interlocked one-shot pulses, level filters.
// Optional macro FP_AUTOREPEAT_EN adds auto-repeat on the dep and exam switches.
module front_panel_sw #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned REPEAT_CYCLES   = 3000000
) (
    input logic             clk,
    input logic             reset,
    front_panel_sw_if.slave sw
);
    localparam int unsigned NM = 6;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // bit 1 set marks the debounced-pressed states (PRESSED, RELEASE_WAIT)
    localparam logic [1:0] RELEASED     = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    // Index order is grant priority: clear, addr_load, extd_addr, dep, exam, cont
    logic [NM-1:0] raw, s1, s2;
    logic [1:0]    lraw, ls1, ls2;
    logic [1:0]    settle;
    logic          settled;
    logic [1:0]    state     [NM];
    logic [1:0]    state_nxt [NM];
    logic [CW-1:0] cnt       [NM];
    logic [CW-1:0] cnt_nxt   [NM];
    logic [NM-1:0] armed, armed_nxt, held, held_nxt, req, rep_req, req_all, grant, pulse;
    logic          busy;
    logic [1:0]    level, level_nxt;
    logic [CW-1:0] lcnt     [2];
    logic [CW-1:0] lcnt_nxt [2];

    assign raw     = {sw.contn, sw.examn, sw.depn, sw.extd_addrn, sw.addr_loadn, sw.clearn};
    assign lraw    = {sw.single_stepn, sw.haltn};
    assign settled = (settle == 2'd2);
    assign req_all = req | rep_req;

    // Synchronisers; settle marks when s2 first holds a real pin sample after reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1     <= '1;
            s2     <= '1;
            ls1    <= '1;
            ls2    <= '1;
            settle <= '0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            ls1 <= lraw;
            ls2 <= ls1;
            if (!settled) settle <= settle + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NM; i++) begin
                state[i] <= RELEASED;
                cnt[i]   <= '0;
            end
            armed   <= '0;
            pulse   <= '0;
            busy    <= 1'b0;
            level   <= 2'b01;
            lcnt[0] <= '0;
            lcnt[1] <= '0;
        end else begin
            for (int i = 0; i < NM; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            armed   <= armed_nxt;
            pulse   <= grant;
            busy    <= |held_nxt;
            level   <= level_nxt;
            lcnt[0] <= lcnt_nxt[0];
            lcnt[1] <= lcnt_nxt[1];
        end
    end

    // Momentary FSMs; a switch arms only after it has been seen released, so one held through reset cannot pulse
    always_comb begin
        armed_nxt = armed;
        req       = '0;
        held      = '0;
        held_nxt  = '0;
        for (int i = 0; i < NM; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            held[i]      = state[i][1];
            case (state[i])
                RELEASED: begin
                    if (!s2[i]) begin
                        state_nxt[i] = PRESS_WAIT;
                        cnt_nxt[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (s2[i]) begin
                        state_nxt[i] = RELEASED;
                    end else if (cnt[i] == DB_LAST) begin
                        state_nxt[i] = PRESSED;
                        req[i]       = armed[i];
                    end else begin
                        cnt_nxt[i] = cnt[i] + CW'(1);
                    end
                end
                PRESSED: begin
                    if (s2[i]) begin
                        state_nxt[i] = RELEASE_WAIT;
                        cnt_nxt[i]   = '0;
                    end
                end
                default: begin
                    if (!s2[i]) begin
                        state_nxt[i] = PRESSED;
                    end else if (cnt[i] == DB_LAST) begin
                        state_nxt[i] = RELEASED;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CW'(1);
                    end
                end
            endcase
            if (settled && s2[i] && !held[i]) armed_nxt[i] = 1'b1;
            held_nxt[i] = state_nxt[i][1];
        end
    end

`ifdef FP_AUTOREPEAT_EN
    localparam int unsigned RPW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPW-1:0] REP_LAST = RPW'(REPEAT_CYCLES - 1);
    localparam logic [NM-1:0]  REPEAT_MASK = 6'b011000;

    logic [RPW-1:0] rep     [NM];
    logic [RPW-1:0] rep_nxt [NM];

    always_comb begin
        rep_req = '0;
        for (int i = 0; i < NM; i++) begin
            rep_nxt[i] = '0;
            if (REPEAT_MASK[i] && (state[i] == PRESSED) && !s2[i] && armed[i]) begin
                if (rep[i] == REP_LAST) rep_req[i] = 1'b1;
                else                    rep_nxt[i] = rep[i] + RPW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NM; i++) begin
            if (!reset) rep[i] <= '0;
            else        rep[i] <= rep_nxt[i];
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYCLES;
    assign rep_req       = '0;
`endif

    // Interlock: grant the highest-priority request whose peers are all idle; the rest are dropped
    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NM; i++) begin
            if (!found && req_all[i] && ((held & ~(NM'(1) << i)) == '0)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Level filters: level is active-high, so level == active-low sync means disagreement
    always_comb begin
        level_nxt = level;
        for (int j = 0; j < 2; j++) begin
            lcnt_nxt[j] = '0;
            if (level[j] == ls2[j]) begin
                if (lcnt[j] == DB_LAST) level_nxt[j] = ~level[j];
                else                    lcnt_nxt[j]  = lcnt[j] + CW'(1);
            end
        end
    end

    assign sw.clear_p     = pulse[0];
    assign sw.addr_load_p = pulse[1];
    assign sw.extd_addr_p = pulse[2];
    assign sw.dep_p       = pulse[3];
    assign sw.exam_p      = pulse[4];
    assign sw.cont_p      = pulse[5];
    assign sw.halt        = level[0];
    assign sw.single_step = level[1];
    assign sw.sw_busy     = busy;
endmodule

// File: tb/tb_front_panel_sw.sv
// Self-checking bench for front_panel_sw: directed scenarios plus random switch activity vs a run-length model.
module tb_front_panel_sw;
    localparam int D = 8;
    localparam int R = 40;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    front_panel_sw_if sw_if ();

    front_panel_sw #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw_if)
    );

    always #5 clk = ~clk;

    wire [5:0] tb_raw  = {sw_if.contn, sw_if.examn, sw_if.depn, sw_if.extd_addrn, sw_if.addr_loadn, sw_if.clearn};
    wire [1:0] tb_lraw = {sw_if.single_stepn, sw_if.haltn};
    wire [8:0] dut_o   = {sw_if.sw_busy, sw_if.single_step, sw_if.halt, sw_if.cont_p, sw_if.exam_p,
                          sw_if.dep_p, sw_if.extd_addr_p, sw_if.addr_load_p, sw_if.clear_p};

    // Reference model: each switch flips its debounced value once the synced pin has disagreed for a run
    // of D+1 samples (momentary) or D samples (level); a rise to pressed requests a pulse if the switch
    // has been seen released since reset.
    bit [5:0] m_q1 = '1, m_q2 = '1, m_d = '0, m_armed = '0, m_p = '0;
    bit [1:0] m_l1 = '1, m_l2 = '1, m_lvl = 2'b01;
    bit       m_busy = 1'b0;
    int       m_settle = 0;
    int       m_run [6];
    int       m_rep [6];
    int       m_lrun [2];
    wire [8:0] exp_o = {m_busy, m_lvl[1], m_lvl[0], m_p};

    always @(posedge clk) begin : ref_model
        bit [5:0] rq, held_pre, arm_now;
        bit done, low, want;
        if (!reset) begin
            m_q1 = '1; m_q2 = '1; m_l1 = '1; m_l2 = '1;
            m_settle = 0; m_d = '0; m_armed = '0; m_p = '0; m_busy = 1'b0; m_lvl = 2'b01;
            for (int i = 0; i < 6; i++) begin m_run[i] = 0; m_rep[i] = 0; end
            m_lrun[0] = 0; m_lrun[1] = 0;
        end else begin
            rq = '0; held_pre = m_d; arm_now = '0;
            for (int i = 0; i < 6; i++) begin
                low = !m_q2[i];
                arm_now[i] = (m_settle == 2) && !low && !m_d[i];
`ifdef FP_AUTOREPEAT_EN
                if ((i == 3 || i == 4) && m_d[i] && m_run[i] == 0 && low && m_armed[i]) begin
                    if (m_rep[i] == R - 1) begin rq[i] = 1'b1; m_rep[i] = 0; end
                    else m_rep[i]++;
                end else m_rep[i] = 0;
`endif
                if (low != m_d[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_d[i] = low; m_run[i] = 0;
                        if (low && m_armed[i]) rq[i] = 1'b1;
                    end
                end else m_run[i] = 0;
            end
            m_armed |= arm_now;
            m_p = '0; done = 1'b0;
            for (int i = 0; i < 6; i++)
                if (!done && rq[i] && ((held_pre & ~(6'(1) << i)) == 6'd0)) begin m_p[i] = 1'b1; done = 1'b1; end
            m_busy = |m_d;
            for (int j = 0; j < 2; j++) begin
                want = !m_l2[j];
                if (want != m_lvl[j]) begin
                    m_lrun[j]++;
                    if (m_lrun[j] == D) begin m_lvl[j] = want; m_lrun[j] = 0; end
                end else m_lrun[j] = 0;
            end
            m_q2 = m_q1; m_q1 = tb_raw; m_l2 = m_l1; m_l1 = tb_lraw;
            if (m_settle < 2) m_settle++;
        end
    end

    task automatic release_all();
        sw_if.examn = 1'b1; sw_if.contn = 1'b1; sw_if.extd_addrn = 1'b1;
        sw_if.addr_loadn = 1'b1; sw_if.clearn = 1'b1; sw_if.depn = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            if (k == 4) reset = 1'b1;
            @(negedge clk);
            n_checks++;
            if (dut_o !== 9'b001_000000) $display("FAIL reset_values cyc %0d: got %b want %b", k, dut_o, 9'b001_000000);
            else n_pass++;
            n_checks++;
            if (dut_o !== exp_o) $display("FAIL reset_model cyc %0d: got %b want %b", k, dut_o, exp_o);
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        int n = 0, at = -1, rise = -1, fall = -1;
        logic bprev = 1'b0;
        for (int k = 1; k <= 55; k++) begin
            if (k == 1)  sw_if.contn = 1'b0;
            if (k == 31) sw_if.contn = 1'b1;
            @(negedge clk);
            n_checks++;
            if (dut_o !== exp_o) $display("FAIL clean_press_model cyc %0d: got %b want %b", k, dut_o, exp_o);
            else n_pass++;
            if (sw_if.cont_p === 1'b1) begin n++; at = k; end
            if (sw_if.sw_busy === 1'b1 && !bprev) rise = k;
            if (sw_if.sw_busy === 1'b0 && bprev)  fall = k;
            bprev = sw_if.sw_busy;
        end
        n_checks++;
        if (n !== 1 || at !== 11) $display("FAIL clean_press_pulse: got %0d pulses last at %0d want 1 at 11", n, at);
        else n_pass++;
        n_checks++;
        if (rise !== 11 || fall !== 41) $display("FAIL clean_press_busy: got rise %0d fall %0d want 11 41", rise, fall);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int n = 0;
        for (int k = 1; k <= 60; k++) begin
            sw_if.addr_loadn = (k <= 40) ? (((k - 1) / 3) % 2 == 1) : 1'b1;
            @(negedge clk);
            n_checks++;
            if (dut_o !== exp_o) $display("FAIL bounce_model cyc %0d: got %b want %b", k, dut_o, exp_o);
            else n_pass++;
            if (sw_if.addr_load_p === 1'b1) n++;
        end
        n_checks++;
        if (n !== 0) $display("FAIL bounce_no_pulse: got %0d pulses want 0", n);
        else n_pass++;
    endtask

    task automatic test_interlock();
        int nc = 0, nd = 0, ne = 0, c_at = -1, e_at = -1;
        for (int k = 1; k <= 90; k++) begin
            if (k == 1)  begin sw_if.clearn = 1'b0; sw_if.depn = 1'b0; end
            if (k == 12) sw_if.examn = 1'b0;
            if (k == 31) release_all();
            if (k == 51) sw_if.examn = 1'b0;
            if (k == 71) sw_if.examn = 1'b1;
            @(negedge clk);
            n_checks++;
            if (dut_o !== exp_o) $display("FAIL interlock_model cyc %0d: got %b want %b", k, dut_o, exp_o);
            else n_pass++;
            if (sw_if.clear_p === 1'b1) begin nc++; c_at = k; end
            if (sw_if.dep_p === 1'b1) nd++;
            if (sw_if.exam_p === 1'b1) begin ne++; e_at = k; end
        end
        n_checks++;
        if (nc !== 1 || c_at !== 11 || nd !== 0) $display("FAIL interlock_priority: got clear %0d at %0d dep %0d want 1 at 11 dep 0", nc, c_at, nd);
        else n_pass++;
        n_checks++;
        if (ne !== 1 || e_at !== 61) $display("FAIL interlock_exam: got %0d pulses last at %0d want 1 at 61", ne, e_at);
        else n_pass++;
    endtask

    task automatic test_level();
        int h_fall = -1, h_rise = -1, s_rise = -1, s_fall = -1, h_drop_early = 0;
        logic hprev = 1'b1, sprev = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 1)  sw_if.haltn = 1'b1;
            if (k == 6)  sw_if.haltn = 1'b0;
            if (k == 26) sw_if.haltn = 1'b1;
            if (k == 46) sw_if.haltn = 1'b0;
            if (k == 66) sw_if.single_stepn = 1'b0;
            if (k == 78) sw_if.single_stepn = 1'b1;
            @(negedge clk);
            n_checks++;
            if (dut_o !== exp_o) $display("FAIL level_model cyc %0d: got %b want %b", k, dut_o, exp_o);
            else n_pass++;
            if (k <= 25 && sw_if.halt !== 1'b1) h_drop_early++;
            if (sw_if.halt === 1'b0 && hprev)  h_fall = k;
            if (sw_if.halt === 1'b1 && !hprev) h_rise = k;
            if (sw_if.single_step === 1'b1 && !sprev) s_rise = k;
            if (sw_if.single_step === 1'b0 && sprev)  s_fall = k;
            hprev = sw_if.halt; sprev = sw_if.single_step;
        end
        n_checks++;
        if (h_drop_early !== 0) $display("FAIL level_short_glitch: got %0d cycles halt=0 want 0", h_drop_early);
        else n_pass++;
        n_checks++;
        if (h_fall !== 35 || h_rise !== 55) $display("FAIL level_halt: got fall %0d rise %0d want 35 55", h_fall, h_rise);
        else n_pass++;
        n_checks++;
        if (s_rise !== 75 || s_fall !== 87) $display("FAIL level_step: got rise %0d fall %0d want 75 87", s_rise, s_fall);
        else n_pass++;
    endtask

    task automatic test_held_at_reset();
        int ne = 0, e_at = -1;
        logic busy11 = 1'b0;
        sw_if.examn = 1'b0;
        reset = 1'b0;
        for (int k = -2; k <= 70; k++) begin
            if (k == 1)  reset = 1'b1;
            if (k == 26) sw_if.examn = 1'b1;
            if (k == 41) sw_if.examn = 1'b0;
            if (k == 61) sw_if.examn = 1'b1;
            @(negedge clk);
            n_checks++;
            if (dut_o !== exp_o) $display("FAIL held_reset_model cyc %0d: got %b want %b", k, dut_o, exp_o);
            else n_pass++;
            if (k == 11) busy11 = sw_if.sw_busy;
            if (sw_if.exam_p === 1'b1) begin ne++; e_at = k; end
        end
        n_checks++;
        if (busy11 !== 1'b1) $display("FAIL held_reset_busy: got %b want 1", busy11);
        else n_pass++;
        n_checks++;
        if (ne !== 1 || e_at !== 51) $display("FAIL held_reset_pulse: got %0d pulses last at %0d want 1 at 51", ne, e_at);
        else n_pass++;
        repeat (14) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int n = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 1) sw_if.contn = 1'b0;
            if (k == 7) begin reset = 1'b0; sw_if.contn = 1'b1; end
            if (k == 10) reset = 1'b1;
            @(negedge clk);
            n_checks++;
            if (dut_o !== exp_o) $display("FAIL reset_abort_model cyc %0d: got %b want %b", k, dut_o, exp_o);
            else n_pass++;
            if (sw_if.cont_p === 1'b1) n++;
        end
        n_checks++;
        if (n !== 0) $display("FAIL reset_abort_pulse: got %0d pulses want 0", n);
        else n_pass++;
    endtask

    task automatic test_autorepeat();
        int got[$];
        int want[$];
`ifdef FP_AUTOREPEAT_EN
        want = '{11, 51, 91};
`else
        want = '{11};
`endif
        for (int k = 1; k <= 120; k++) begin
            if (k == 1)   sw_if.depn = 1'b0;
            if (k == 101) sw_if.depn = 1'b1;
            @(negedge clk);
            n_checks++;
            if (dut_o !== exp_o) $display("FAIL autorepeat_model cyc %0d: got %b want %b", k, dut_o, exp_o);
            else n_pass++;
            if (sw_if.dep_p === 1'b1) got.push_back(k);
        end
        n_checks++;
        if (got.size() !== want.size()) $display("FAIL autorepeat_count: got %0d pulses want %0d", got.size(), want.size());
        else n_pass++;
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== want[i]) $display("FAIL autorepeat_cycle %0d: got %0d want %0d", i, got[i], want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int hold [8];
        logic [7:0] v;
        v = {sw_if.single_stepn, sw_if.haltn, tb_raw};
        for (int i = 0; i < 8; i++) hold[i] = int'($urandom_range(1, 20));
        for (int k = 1; k <= 3000; k++) begin
            for (int i = 0; i < 8; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    v[i] = ~v[i];
                    hold[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 12));
                end
            end
            if (k > 2970) v = 8'b10_111111;
            {sw_if.single_stepn, sw_if.haltn, sw_if.contn, sw_if.examn, sw_if.depn,
             sw_if.extd_addrn, sw_if.addr_loadn, sw_if.clearn} = v;
            @(negedge clk);
            n_checks++;
            if (dut_o !== exp_o) $display("FAIL random_model cyc %0d: got %b want %b", k, dut_o, exp_o);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b0;
        release_all();
        sw_if.haltn        = 1'b0;
        sw_if.single_stepn = 1'b1;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_interlock();
        test_level();
        test_held_at_reset();
        test_reset_abort();
        test_autorepeat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
